// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter and long-latency destination scoreboard.
//
// Owns the single register-file write port (WE3/A3/WD3). Two writeback
// sources compete for it. The ALU path is single-cycle. The memory path is
// long-latency. Arbitration is round-robin: the pointer flips only when both
// sources request in the same cycle. The granted write is registered, so
// rf_* follows acceptance by one cycle.
//
// The scoreboard marks the destination of every issued long-latency op as
// busy. A busy bit stays set until the memory-path write for that register
// leaves the output register. Decode stalls while any source, or the
// destination of the op being issued, is busy.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   alu_valid/rd/data, ready    ALU writeback handshake
//   mem_valid/rd/data, ready    long-latency writeback handshake
//   iss_valid, iss_rd           long-latency issue (marks rd busy)
//   rs1, rs2                    decode source registers
//   hz_stall                    decode must stall (combinational)
//   rf_we, rf_a3, rf_wd         register file write port
//   pending_cnt                 number of busy registers
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [$clog2(NREG)-1:0]      alu_rd,
  input  logic [XLEN-1:0]              alu_data,
  output logic                         alu_ready,
  input  logic                         mem_valid,
  input  logic [$clog2(NREG)-1:0]      mem_rd,
  input  logic [XLEN-1:0]              mem_data,
  output logic                         mem_ready,
  input  logic                         iss_valid,
  input  logic [$clog2(NREG)-1:0]      iss_rd,
  input  logic [$clog2(NREG)-1:0]      rs1,
  input  logic [$clog2(NREG)-1:0]      rs2,
  output logic                         hz_stall,
  output logic                         rf_we,
  output logic [$clog2(NREG)-1:0]      rf_a3,
  output logic [XLEN-1:0]              rf_wd,
  output logic [$clog2(NREG+1)-1:0]    pending_cnt
);

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);
  localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

  function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // ptr_mem = 1 means the memory path wins the next contention.
  logic            ptr_mem;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [CW-1:0]   cnt_q;

  logic            vld_p1;
  logic [AW-1:0]   a3_p1;
  logic [XLEN-1:0] wd_p1;
  logic            src_p1;

  always_comb begin
    alu_ready = alu_valid && (!mem_valid || !ptr_mem);
    mem_ready = mem_valid && (!alu_valid ||  ptr_mem);
    hz_stall  = busy[rs1] | busy[rs2] | (iss_valid & busy[iss_rd]);
  end

  // Set has priority over clear. Bit 0 is forced low so x0 can never be busy.
  always_comb begin
    set_vec  = (iss_valid && (iss_rd != '0) && !hz_stall) ? (ONE_HOT0 << iss_rd) : '0;
    clr_vec  = (vld_p1 && src_p1) ? (ONE_HOT0 << a3_p1) : '0;
    busy_nxt = ((busy & ~clr_vec) | set_vec) & ~ONE_HOT0;
  end

  // ---- stage p0 -> p1: arbitration result into the write-port register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      a3_p1   <= '0;
      wd_p1   <= '0;
      src_p1  <= 1'b0;
      ptr_mem <= 1'b0;
    end else begin
      if (alu_ready) begin
        // A write to x0 is accepted but never reaches the register file.
        vld_p1 <= (alu_rd != '0);
        a3_p1  <= alu_rd;
        wd_p1  <= alu_data;
        src_p1 <= 1'b0;
      end else if (mem_ready) begin
        vld_p1 <= (mem_rd != '0);
        a3_p1  <= mem_rd;
        wd_p1  <= mem_data;
        src_p1 <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
      if (alu_valid && mem_valid) begin
        ptr_mem <= !ptr_mem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      busy  <= busy_nxt;
      cnt_q <= popcount(busy_nxt);
    end
  end

  assign rf_we       = vld_p1;
  assign rf_a3       = a3_p1;
  assign rf_wd       = wd_p1;
  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, iss_valid;
  logic [4:0]  alu_rd, mem_rd, iss_rd, rs1, rs2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, hz_stall, rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [5:0]  pending_cnt;

  regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2), .hz_stall(hz_stall),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_busy[32];
  bit          m_ptr_mem;
  bit          m_we;
  bit          m_src;
  int          m_a3;
  logic [31:0] m_wd;

  // DUT combinational outputs as seen during the last cycle
  logic s_alu_ready, s_mem_ready, s_hz;
  bit   last_ga, last_gm;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    m_ptr_mem = 1'b0;
    m_we  = 1'b0;
    m_src = 1'b0;
    m_a3  = 0;
    m_wd  = '0;
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; iss_valid = 0;
    alu_rd = 0; mem_rd = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    alu_data = 0; mem_data = 0; rst = 0;
  endtask

  // One clock cycle: check combinational outputs against the model, advance
  // both, then check the registered outputs.
  task automatic cycle();
    bit ga, gm, stall;
    bit nb[32];
    int cnt;
    #1;
    ga = alu_valid && (!mem_valid || !m_ptr_mem);
    gm = mem_valid && (!alu_valid ||  m_ptr_mem);
    stall = m_busy[rs1] || m_busy[rs2] || (iss_valid && m_busy[iss_rd]);
    s_alu_ready = alu_ready; s_mem_ready = mem_ready; s_hz = hz_stall;
    chk("alu_ready", {31'b0, alu_ready}, {31'b0, ga});
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, gm});
    chk("hz_stall",  {31'b0, hz_stall},  {31'b0, stall});
    last_ga = ga; last_gm = gm;
    nb = m_busy;
    if (m_we && m_src) nb[m_a3] = 1'b0;
    if (iss_valid && iss_rd != 0 && !stall) nb[iss_rd] = 1'b1;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_busy = nb;
      if (alu_valid && mem_valid) m_ptr_mem = !m_ptr_mem;
      if (ga) begin
        m_we = (alu_rd != 0); m_src = 1'b0;
        if (alu_rd != 0) begin m_a3 = alu_rd; m_wd = alu_data; end
      end else if (gm) begin
        m_we = (mem_rd != 0); m_src = 1'b1;
        if (mem_rd != 0) begin m_a3 = mem_rd; m_wd = mem_data; end
      end else begin
        m_we = 1'b0;
      end
    end
    chk("rf_we", {31'b0, rf_we}, {31'b0, m_we});
    if (m_we) begin
      chk("rf_a3", {27'b0, rf_a3}, m_a3);
      chk("rf_wd", rf_wd, m_wd);
    end
    cnt = 0;
    for (int r = 0; r < 32; r++) cnt += m_busy[r];
    chk("pending_cnt", {26'b0, pending_cnt}, cnt);
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    // Reset state
    chk("rst_rf_we", {31'b0, rf_we}, 0);
    chk("rst_rf_a3", {27'b0, rf_a3}, 0);
    chk("rst_rf_wd", rf_wd, 0);
    chk("rst_pending", {26'b0, pending_cnt}, 0);
    #1;
    chk("rst_alu_ready", {31'b0, alu_ready}, 0);
    chk("rst_mem_ready", {31'b0, mem_ready}, 0);

    // Single ALU writeback, latency 1
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234_5678;
    cycle();
    chk("t1_alu_ready", {31'b0, s_alu_ready}, 1);
    chk("t1_rf_we", {31'b0, rf_we}, 1);
    chk("t1_rf_a3", {27'b0, rf_a3}, 5);
    chk("t1_rf_wd", rf_wd, 32'h1234_5678);
    idle(); cycle();
    chk("t1_rf_we_off", {31'b0, rf_we}, 0);

    // Contention for three cycles: ALU, mem, ALU
    alu_valid = 1; alu_rd = 1; alu_data = 32'hA;
    mem_valid = 1; mem_rd = 2; mem_data = 32'hB;
    cycle(); chk("t2_a3_0", {27'b0, rf_a3}, 1);
    cycle(); chk("t2_a3_1", {27'b0, rf_a3}, 2);
    cycle(); chk("t2_a3_2", {27'b0, rf_a3}, 1);
    cycle(); chk("t2_ptr_mem", {31'b0, s_mem_ready}, 1);
    idle(); cycle();

    // Issue rd=7, stall on rs1=7 until the mem write lands
    iss_valid = 1; iss_rd = 7;
    cycle();
    chk("t3_pending", {26'b0, pending_cnt}, 1);
    idle(); rs1 = 7;
    cycle(); chk("t3_stall0", {31'b0, s_hz}, 1);
    mem_valid = 1; mem_rd = 7; mem_data = 32'hDEAD;
    cycle(); chk("t3_mem_ready", {31'b0, s_mem_ready}, 1);
    chk("t3_we7", {27'b0, rf_a3}, 7);
    mem_valid = 0;
    cycle(); chk("t3_stall_at_we", {31'b0, s_hz}, 1);
    chk("t3_pending0", {26'b0, pending_cnt}, 0);
    cycle(); chk("t3_stall_clear", {31'b0, s_hz}, 0);
    idle(); cycle();

    // Writes and issues to x0 have no effect
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
    iss_valid = 1; iss_rd = 0;
    cycle();
    chk("t4_alu_ready", {31'b0, s_alu_ready}, 1);
    chk("t4_hz", {31'b0, s_hz}, 0);
    chk("t4_rf_we", {31'b0, rf_we}, 0);
    idle(); cycle();
    chk("t4_pending", {26'b0, pending_cnt}, 0);

    // Re-issue to busy rd=9 around its writeback
    iss_valid = 1; iss_rd = 9;
    cycle();
    iss_valid = 0; mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
    cycle();
    mem_valid = 0; iss_valid = 1; iss_rd = 9;
    cycle(); chk("t5_iss_busy_stall", {31'b0, s_hz}, 1);
    cycle();
    idle(); cycle();

    // Reset while a mem write sits in the output register
    iss_valid = 1; iss_rd = 3; cycle();
    iss_rd = 4; cycle();
    iss_valid = 0; mem_valid = 1; mem_rd = 3; mem_data = 32'h33;
    cycle();
    mem_valid = 0; rst = 1;
    cycle();
    rst = 0; rs1 = 3; rs2 = 4;
    chk("t6_rf_we", {31'b0, rf_we}, 0);
    chk("t6_pending", {26'b0, pending_cnt}, 0);
    alu_valid = 1; alu_rd = 6; alu_data = 6; mem_valid = 1; mem_rd = 8; mem_data = 8;
    cycle();
    chk("t6_hz", {31'b0, s_hz}, 0);
    chk("t6_ptr_alu", {31'b0, s_alu_ready}, 1);
    idle(); cycle();

    // Randomized traffic with handshake-stable sources
    for (int i = 0; i < 400; i++) begin
      if (!(alu_valid && !last_ga)) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
      end
      if (!(mem_valid && !last_gm)) begin
        mem_valid = ($urandom_range(0, 9) < 5);
        mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
      end
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rd = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 79) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
